ddr4_axi_wr_cmd_fsm: RTL and testbench

// - Write-command sequencer for the AXI slave. Sits beside the W-channel stage; feeds its w_cmd_rdy.
// - Issues one MC write command per translated BL8/BL4 address beat, but only when a full data beat
//   is ready (w_data_rdy), keeping the command and WDF streams in lock-step.
// - Steps the address translator (cmd_next) after each accepted command.
// - Completes the AXI AW handshake and pushes one entry to the B-response FIFO per burst.

---
 rtl/ddr4_axi_pkg.sv | 19 +
 rtl/ddr4_axi_wr_cmd_fsm.sv | 104 ++++++++++
 tb/tb_ddr4_axi_wr_cmd_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ddr4_axi_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_axi_pkg
// Shared definitions for the DDR4 AXI slave write path.
//   - sm_state_t : write-command sequencer states
//   - CMD_*      : memory-controller command codes
// ---------------------------------------------------------------------------
package ddr4_axi_pkg;

  typedef enum logic [1:0] {
    SM_IDLE         = 2'd0,
    SM_CMD_EN       = 2'd1,
    SM_CMD_ACCEPTED = 2'd2,
    SM_DONE_WAIT    = 2'd3
  } sm_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage : ddr4_axi_pkg

// File: rtl/ddr4_axi_wr_cmd_fsm.sv
// ---------------------------------------------------------------------------
// ddr4_axi_wr_cmd_fsm
// Write-command sequencer for the AXI slave. Issues one MC write command per
// translated address beat, but only while the W stage has a full data beat, so
// the command stream and the write-data FIFO stay in lock-step. Retires the
// AW burst and pushes one B-response entry per burst.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   s_awvalid       : translator holds a valid write burst
//   s_awready       : burst retired (last command accepted, B slot free)
//   next_pending    : translator has more MC commands for this burst
//   cmd_next        : pulse, translator advances to next MC address
//   w_data_rdy      : W stage has a full beat and WDF has room
//   w_cmd_rdy       : pulse, W stage pushes its beat (same cycle as command)
//   mc_app_en       : MC command valid
//   mc_app_cmd      : MC command code, always write
//   mc_app_rdy      : MC accepts command
//   b_push          : push burst ID into B-response FIFO
//   b_full          : B-response FIFO full
//   cmd_cnt         : commands accepted so far in current burst
// ---------------------------------------------------------------------------
module ddr4_axi_wr_cmd_fsm
  import ddr4_axi_pkg::*;
#(
  parameter int C_MC_BURST_LEN = 1,
  parameter int C_CNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic                   next_pending,
  output logic                   cmd_next,
  input  logic                   w_data_rdy,
  output logic                   w_cmd_rdy,
  output logic                   mc_app_en,
  output logic [2:0]             mc_app_cmd,
  input  logic                   mc_app_rdy,
  output logic                   b_push,
  input  logic                   b_full,
  output logic [C_CNT_WIDTH-1:0] cmd_cnt
);

  // Burst length does not affect sequencing; only legal values are accepted.
  if (C_MC_BURST_LEN < 1 || C_MC_BURST_LEN > 2) begin : g_bad_burst_len
    $error("ddr4_axi_wr_cmd_fsm: C_MC_BURST_LEN must be 1 or 2");
  end

  sm_state_t              r_state;
  sm_state_t              w_state_nxt;
  logic [C_CNT_WIDTH-1:0] r_cmd_cnt;
  logic                   w_hs;
  logic                   w_retire;

  // Never present a command without its data beat.
  assign mc_app_en  = (r_state == SM_CMD_EN) & w_data_rdy;
  assign mc_app_cmd = CMD_WRITE;
  assign w_hs       = mc_app_en & mc_app_rdy;
  assign w_cmd_rdy  = w_hs;
  assign cmd_next   = w_hs;

  // Retire either on the final handshake with a free B slot, or later once
  // the B FIFO drains.
  assign w_retire   = ((r_state == SM_CMD_EN) & w_hs & ~next_pending & ~b_full) |
                      ((r_state == SM_DONE_WAIT) & ~b_full);
  assign s_awready  = w_retire;
  assign b_push     = w_retire;
  assign cmd_cnt    = r_cmd_cnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SM_IDLE:
        if (s_awvalid && !b_full) w_state_nxt = SM_CMD_EN;
      SM_CMD_EN:
        if (w_hs) begin
          if (next_pending) w_state_nxt = SM_CMD_ACCEPTED;
          else if (b_full)  w_state_nxt = SM_DONE_WAIT;
          else              w_state_nxt = SM_IDLE;
        end
      // One bubble lets the translator's next address settle.
      SM_CMD_ACCEPTED:
        w_state_nxt = SM_CMD_EN;
      SM_DONE_WAIT:
        if (!b_full) w_state_nxt = SM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SM_IDLE;
      r_cmd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Clear on retirement wins over the final increment; saturate at max.
      if (w_retire)
        r_cmd_cnt <= '0;
      else if (w_hs && (r_cmd_cnt != {C_CNT_WIDTH{1'b1}}))
        r_cmd_cnt <= r_cmd_cnt + C_CNT_WIDTH'(1);
    end
  end

endmodule : ddr4_axi_wr_cmd_fsm

// File: tb/tb_ddr4_axi_wr_cmd_fsm.sv
// ---------------------------------------------------------------------------
// tb_ddr4_axi_wr_cmd_fsm
// Directed bench for the write-command sequencer. Inputs change 1 time unit
// after the rising edge; combinational outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_ddr4_axi_wr_cmd_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_awvalid, s_awready;
  logic       next_pending, cmd_next;
  logic       w_data_rdy, w_cmd_rdy;
  logic       mc_app_en;
  logic [2:0] mc_app_cmd;
  logic       mc_app_rdy;
  logic       b_push, b_full;
  logic [7:0] cmd_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr4_axi_wr_cmd_fsm #(.C_MC_BURST_LEN(1), .C_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .next_pending(next_pending), .cmd_next(cmd_next),
    .w_data_rdy(w_data_rdy), .w_cmd_rdy(w_cmd_rdy),
    .mc_app_en(mc_app_en), .mc_app_cmd(mc_app_cmd), .mc_app_rdy(mc_app_rdy),
    .b_push(b_push), .b_full(b_full), .cmd_cnt(cmd_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs may then be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after input changes.
  task automatic settle();
    #1;
  endtask

  // Check the full output vector at once: {en, hs-pulse, retire-pulse, cnt}.
  task automatic chk_out(input string tag, input logic en, input logic hs,
                         input logic ret, input logic [7:0] cnt);
    chk({tag, ".en"},   32'(mc_app_en), 32'(en));
    chk({tag, ".wcmd"}, 32'(w_cmd_rdy), 32'(hs));
    chk({tag, ".next"}, 32'(cmd_next),  32'(hs));
    chk({tag, ".awr"},  32'(s_awready), 32'(ret));
    chk({tag, ".bpush"},32'(b_push),    32'(ret));
    chk({tag, ".cnt"},  32'(cmd_cnt),   32'(cnt));
  endtask

  initial begin
    reset = 1'b1; s_awvalid = 0; next_pending = 0; w_data_rdy = 0;
    mc_app_rdy = 0; b_full = 0;
    tick(); tick();

    // Reset state
    settle();
    chk_out("rst", 0, 0, 0, 8'd0);
    chk("rst.cmd", 32'(mc_app_cmd), 32'd0);

    // Single beat
    reset = 0; s_awvalid = 1; next_pending = 0; w_data_rdy = 1; mc_app_rdy = 1;
    settle();
    chk_out("sb.idle", 0, 0, 0, 8'd0);
    tick(); s_awvalid = 0; settle();
    chk_out("sb.cmd", 1, 1, 1, 8'd0);
    chk("sb.code", 32'(mc_app_cmd), 32'd0);
    tick(); settle();
    chk_out("sb.after", 0, 0, 0, 8'd0);

    // 4-command burst, commands every other cycle
    s_awvalid = 1; next_pending = 1;
    tick(); s_awvalid = 0;
    for (int k = 0; k < 4; k++) begin
      next_pending = (k < 3);
      settle();
      chk_out($sformatf("b4.cmd%0d", k), 1, 1, (k == 3), 8'(k));
      tick();
      if (k < 3) begin
        settle();
        chk_out($sformatf("b4.bub%0d", k), 0, 0, 0, 8'(k + 1));
        tick();
      end
    end
    settle();
    chk_out("b4.idle", 0, 0, 0, 8'd0);

    // Data stall for 5 cycles in CMD_EN
    s_awvalid = 1; next_pending = 0; w_data_rdy = 0;
    tick(); s_awvalid = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk_out($sformatf("ds.%0d", k), 0, 0, 0, 8'd0);
      tick();
    end
    w_data_rdy = 1; settle();
    chk_out("ds.go", 1, 1, 1, 8'd0);
    tick();

    // MC backpressure for 3 cycles
    s_awvalid = 1; mc_app_rdy = 0;
    tick(); s_awvalid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_out($sformatf("bp.%0d", k), 1, 0, 0, 8'd0);
      tick();
    end
    mc_app_rdy = 1; settle();
    chk_out("bp.go", 1, 1, 1, 8'd0);
    tick();

    // B FIFO full on the final handshake, released 4 cycles later
    s_awvalid = 1;
    tick(); s_awvalid = 0; b_full = 1; settle();
    chk_out("bf.hs", 1, 1, 0, 8'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_out($sformatf("bf.wait%0d", k), 0, 0, 0, 8'd1);
      tick();
    end
    b_full = 0; settle();
    chk_out("bf.rel", 0, 0, 1, 8'd1);
    tick(); settle();
    chk_out("bf.idle", 0, 0, 0, 8'd0);

    // awvalid held at retirement: one IDLE cycle, then next burst
    s_awvalid = 1;
    tick(); settle();
    chk_out("bb.cmd0", 1, 1, 1, 8'd0);
    tick(); settle();
    chk_out("bb.idle", 0, 0, 0, 8'd0);
    tick(); settle();
    chk_out("bb.cmd1", 1, 1, 1, 8'd0);
    s_awvalid = 0;
    tick();

    // Counter saturation: 260-command burst
    s_awvalid = 1; next_pending = 1;
    tick(); s_awvalid = 0;
    for (int k = 0; k < 259; k++) begin
      tick(); tick();
    end
    next_pending = 0; settle();
    chk_out("sat.last", 1, 1, 1, 8'd255);
    tick(); settle();
    chk_out("sat.idle", 0, 0, 0, 8'd0);

    // Reset after 2 of 4 commands
    s_awvalid = 1; next_pending = 1;
    tick(); s_awvalid = 0;
    tick(); tick(); tick(); tick();
    settle();
    chk_out("rm.pre", 1, 1, 0, 8'd2);
    reset = 1;
    tick(); settle();
    chk_out("rm.rst", 0, 0, 0, 8'd0);
    reset = 0;
    tick(); settle();
    chk_out("rm.idle", 0, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Watchdog: the sequence is fully directed, so this only guards a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_ddr4_axi_wr_cmd_fsm
